// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory signals around mem_port_arbiter.
// Ports: none; signals grouped per requester; slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_gnt;
    logic       f_valid;
    logic [7:0] f_instr;
    logic [7:0] f_imm;
    logic       f_imm_en;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_gnt;
    logic       d_valid;
    logic [7:0] d_rdata;
    logic [7:0] m_addr;
    logic       m_we;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output f_gnt, f_valid, f_instr, f_imm, f_imm_en,
               d_gnt, d_valid, d_rdata, m_addr, m_we, m_wdata
    );
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  f_gnt, f_valid, f_instr, f_imm, f_imm_en,
               d_gnt, d_valid, d_rdata, m_addr, m_we, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 256x8 memory between fetch (with two-byte immediate fetch) and data accesses.
// Ports: clk, rst (sync, active-low), bus (mem_port_arbiter_if.slave: fetch f_*, data d_*, memory m_*).
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX data grants with fetch waiting, fetch wins once.
module mem_port_arbiter #(
    parameter logic [3:0] IMM_OPC    = 4'hC,
    parameter int         STARVE_MAX = 3
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic {IDLE, IMM} state_t;
    state_t     state, state_n;
    logic [7:0] imm_addr, opc;
    logic       gnt_f, gnt_d, f_force, is_imm;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be within 1..15");
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve;
    assign f_force = starve == 4'(STARVE_MAX) && bus.f_req && bus.d_req;
    always_ff @(posedge clk)
        if (!rst || gnt_f || !bus.f_req) starve <= 4'd0;
        else if (gnt_d) starve <= starve + 4'd1;
`else
    assign f_force = 1'b0;
`endif

    // Opcode byte is on m_rdata during the fetch grant; its high nibble picks the two-byte path.
    assign is_imm = gnt_f && bus.m_rdata[7:4] == IMM_OPC;

    always_comb begin
        gnt_d       = rst && state == IDLE && bus.d_req && !f_force;
        gnt_f       = rst && state == IDLE && bus.f_req && !gnt_d;
        bus.f_gnt   = gnt_f;
        bus.d_gnt   = gnt_d;
        bus.m_we    = gnt_d && bus.d_we;
        bus.m_wdata = bus.m_we ? bus.d_wdata : 8'h00;
        bus.m_addr  = state == IMM ? imm_addr : gnt_d ? bus.d_addr : gnt_f ? bus.f_addr : 8'h00;
    end

    always_comb begin
        state_n = state == IDLE && is_imm ? IMM : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            imm_addr     <= 8'h00;
            opc          <= 8'h00;
            bus.f_valid  <= 1'b0;
            bus.f_instr  <= 8'h00;
            bus.f_imm    <= 8'h00;
            bus.f_imm_en <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.d_rdata  <= 8'h00;
        end else begin
            state       <= state_n;
            bus.f_valid <= (gnt_f && !is_imm) || state == IMM;
            bus.d_valid <= gnt_d;
            // Opcode is staged privately so f_instr only changes together with f_valid.
            if (gnt_f) begin
                opc      <= bus.m_rdata;
                imm_addr <= bus.f_addr + 8'd1;
            end
            if (gnt_f && !is_imm) begin
                bus.f_instr  <= bus.m_rdata;
                bus.f_imm    <= 8'h00;
                bus.f_imm_en <= 1'b0;
            end
            if (state == IMM) begin
                bus.f_instr  <= opc;
                bus.f_imm    <= bus.m_rdata;
                bus.f_imm_en <= 1'b1;
            end
            if (gnt_d && !bus.d_we) bus.d_rdata <= bus.m_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a behavioural 256x8 memory.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem [256];
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
    int         checks = 0, errors = 0;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.IMM_OPC(4'hC), .STARVE_MAX(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.m_rdata = mem[bus.m_addr];
    always @(posedge clk)
        if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
        else if (pl_we) mem[pl_addr] <= pl_data;

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset;
        bus.f_req = 1'b1; bus.f_addr = 8'h00; bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 8'h00; bus.d_wdata = 8'h55; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL reset_f_gnt got %b want 0", bus.f_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %b want 0", bus.d_gnt); end
        checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we got %b want 0", bus.m_we); end
        checks++; if ({bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en, bus.d_valid, bus.d_rdata} !== 27'd0) begin
            errors++; $display("FAIL reset_regs got fv=%b fi=%h fm=%h fe=%b dv=%b dr=%h want all 0",
                bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en, bus.d_valid, bus.d_rdata);
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_single_fetch;
        preload(8'h10, 8'h35);
        bus.f_req = 1'b1; bus.f_addr = 8'h10;
        #1;
        checks++; if (bus.f_gnt !== 1'b1 || bus.m_addr !== 8'h10) begin errors++; $display("FAIL single_grant got gnt=%b addr=%h want 1 10", bus.f_gnt, bus.m_addr); end
        @(posedge clk); #1;
        checks++; if ({bus.f_valid, bus.f_instr, bus.f_imm_en, bus.f_imm} !== {1'b1, 8'h35, 1'b0, 8'h00}) begin
            errors++; $display("FAIL single_result got v=%b i=%h e=%b m=%h want 1 35 0 00", bus.f_valid, bus.f_instr, bus.f_imm_en, bus.f_imm);
        end
        @(negedge clk); bus.f_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.f_valid !== 1'b0 || bus.f_instr !== 8'h35) begin errors++; $display("FAIL single_hold got v=%b i=%h want 0 35", bus.f_valid, bus.f_instr); end
    endtask

    task automatic test_imm_wrap;
        preload(8'hFF, 8'hC2);
        preload(8'h00, 8'h7A);
        bus.f_req = 1'b1; bus.f_addr = 8'hFF;
        #1;
        checks++; if (bus.f_gnt !== 1'b1 || bus.m_addr !== 8'hFF) begin errors++; $display("FAIL imm_grant got gnt=%b addr=%h want 1 ff", bus.f_gnt, bus.m_addr); end
        @(posedge clk); #1;
        checks++; if (bus.f_valid !== 1'b0) begin errors++; $display("FAIL imm_early_valid got %b want 0", bus.f_valid); end
        @(negedge clk);
        bus.f_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
        #1;
        checks++; if ({bus.d_gnt, bus.f_gnt, bus.m_addr} !== {1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL imm_lock got dg=%b fg=%b addr=%h want 0 0 00", bus.d_gnt, bus.f_gnt, bus.m_addr);
        end
        @(posedge clk); #1;
        checks++; if ({bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en} !== {1'b1, 8'hC2, 8'h7A, 1'b1}) begin
            errors++; $display("FAIL imm_result got v=%b i=%h m=%h e=%b want 1 c2 7a 1", bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en);
        end
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL imm_then_data got %b want 1", bus.d_gnt); end
        @(posedge clk); #1;
        checks++; if ({bus.d_valid, bus.d_rdata, bus.f_valid} !== {1'b1, 8'h35, 1'b0}) begin
            errors++; $display("FAIL imm_data_read got dv=%b dr=%h fv=%b want 1 35 0", bus.d_valid, bus.d_rdata, bus.f_valid);
        end
        @(negedge clk); bus.d_req = 1'b0;
    endtask

    task automatic test_store_load;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h40; bus.d_wdata = 8'h99;
        #1;
        checks++; if ({bus.d_gnt, bus.m_we, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b1, 8'h40, 8'h99}) begin
            errors++; $display("FAIL store_grant got g=%b we=%b a=%h wd=%h want 1 1 40 99", bus.d_gnt, bus.m_we, bus.m_addr, bus.m_wdata);
        end
        @(posedge clk); #1;
        checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 8'h35) begin errors++; $display("FAIL store_valid got v=%b r=%h want 1 35", bus.d_valid, bus.d_rdata); end
        @(negedge clk); bus.d_we = 1'b0;
        #1;
        checks++; if ({bus.d_gnt, bus.m_we, bus.m_addr, bus.m_wdata} !== {1'b1, 1'b0, 8'h40, 8'h00}) begin
            errors++; $display("FAIL load_grant got g=%b we=%b a=%h wd=%h want 1 0 40 00", bus.d_gnt, bus.m_we, bus.m_addr, bus.m_wdata);
        end
        @(posedge clk); #1;
        checks++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 8'h99) begin errors++; $display("FAIL load_result got v=%b r=%h want 1 99", bus.d_valid, bus.d_rdata); end
        @(negedge clk); bus.d_req = 1'b0;
        #1;
        checks++; if (bus.d_gnt !== 1'b0 || bus.m_addr !== 8'h00) begin errors++; $display("FAIL no_grant got g=%b a=%h want 0 00", bus.d_gnt, bus.m_addr); end
        @(posedge clk); #1;
        checks++; if (bus.d_valid !== 1'b0 || bus.d_rdata !== 8'h99) begin errors++; $display("FAIL load_hold got v=%b r=%h want 0 99", bus.d_valid, bus.d_rdata); end
    endtask

    task automatic test_starve;
        logic exp_f;
        int   n_cyc;
`ifdef ARB_STARVE_GUARD_EN
        n_cyc = 12;
`else
        n_cyc = 10;
`endif
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h40; bus.f_req = 1'b1; bus.f_addr = 8'h10;
        for (int i = 0; i < n_cyc; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_f = (i % 4) == 3;
`else
            exp_f = 1'b0;
`endif
            #1;
            checks++; if (bus.f_gnt !== exp_f || bus.d_gnt !== !exp_f) begin
                errors++; $display("FAIL starve_grant cycle %0d got fg=%b dg=%b want fg=%b dg=%b", i, bus.f_gnt, bus.d_gnt, exp_f, !exp_f);
            end
            @(posedge clk); #1;
            checks++; if (bus.f_valid !== exp_f || bus.d_valid !== !exp_f) begin
                errors++; $display("FAIL starve_valid cycle %0d got fv=%b dv=%b want fv=%b dv=%b", i, bus.f_valid, bus.d_valid, exp_f, !exp_f);
            end
            @(negedge clk);
        end
        bus.d_req = 1'b0; bus.f_req = 1'b0;
    endtask

    task automatic test_reset_in_imm;
        preload(8'h20, 8'hC5);
        preload(8'h21, 8'h11);
        bus.f_req = 1'b1; bus.f_addr = 8'h20;
        #1;
        checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL rimm_grant got %b want 1", bus.f_gnt); end
        @(negedge clk);
        bus.f_req = 1'b0; rst = 1'b0;
        #1;
        checks++; if (bus.f_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.m_we !== 1'b0) begin
            errors++; $display("FAIL rimm_comb got fg=%b dg=%b we=%b want 0 0 0", bus.f_gnt, bus.d_gnt, bus.m_we);
        end
        @(posedge clk); #1;
        checks++; if ({bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en, bus.d_valid, bus.d_rdata} !== 27'd0) begin
            errors++; $display("FAIL rimm_regs got fv=%b fi=%h fm=%h fe=%b dv=%b dr=%h want all 0",
                bus.f_valid, bus.f_instr, bus.f_imm, bus.f_imm_en, bus.d_valid, bus.d_rdata);
        end
        @(negedge clk);
        rst = 1'b1; bus.f_req = 1'b1; bus.f_addr = 8'h10;
        #1;
        checks++; if (bus.f_gnt !== 1'b1 || bus.m_addr !== 8'h10) begin errors++; $display("FAIL rimm_idle got gnt=%b addr=%h want 1 10", bus.f_gnt, bus.m_addr); end
        @(posedge clk); #1;
        checks++; if ({bus.f_valid, bus.f_instr, bus.f_imm_en, bus.f_imm} !== {1'b1, 8'h35, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rimm_refetch got v=%b i=%h e=%b m=%h want 1 35 0 00", bus.f_valid, bus.f_instr, bus.f_imm_en, bus.f_imm);
        end
        @(negedge clk); bus.f_req = 1'b0;
    endtask

    initial begin
        bus.f_req = 1'b0; bus.f_addr = 8'h00; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        test_reset();
        test_single_fetch();
        test_imm_wrap();
        test_store_load();
        test_starve();
        test_reset_in_imm();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
